// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM states,
// datapath width, the NOP encoding and the decode field positions.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Bit positions of the decode fields inside a 32-bit instruction word.
    localparam int OP_LSB     = 0;
    localparam int OP_MSB     = 6;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one word request at a time,
// holds the returned instruction for the control unit and applies redirects.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] Instr,
    output logic [6:0]      Op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            fault,
    output logic [XLEN-1:0] retire_count
);

    fetch_state_e    state_q, state_d;
    logic            idle_done_q, idle_done_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] retire_q, retire_d;
    logic            fault_q, fault_d;

    logic            consume;
    logic            bad_redirect;
    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4     = pc_q + 32'd4;
    assign consume      = (state_q == HOLD) && instr_ready;
    assign bad_redirect = PCSrc && (PCTarget[1:0] != 2'b00);

    // NOTE: every signal assigned here gets its default first, so no path
    // through the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        idle_done_d = idle_done_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        retire_d    = retire_q;
        fault_d     = fault_q;

        unique case (state_q)
            IDLE: begin
                // Stay one full cycle in IDLE after reset is released.
                idle_done_d = 1'b1;
                if (idle_done_q) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    instr_d = imem_rsp_data;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (consume) begin
                    retire_d = retire_q + 32'd1;
                    if (bad_redirect) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else begin
                        pc_d    = PCSrc ? PCTarget : pc_plus4;
                        state_d = REQ;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, and reset is
    // sampled on the clock edge like any other input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            idle_done_q <= 1'b0;
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            retire_q    <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_done_q <= idle_done_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            retire_q    <= retire_d;
            fault_q     <= fault_d;
        end
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = (state_q == HOLD);
    assign Instr          = instr_q;
    assign Op             = instr_q[OP_MSB:OP_LSB];
    assign funct3         = instr_q[FUNCT3_MSB:FUNCT3_LSB];
    assign funct7         = instr_q[FUNCT7_MSB:FUNCT7_LSB];
    assign PC             = pc_q;
    assign PCPlus4        = pc_plus4;
    assign fault          = fault_q;
    assign retire_count   = retire_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: randomized memory latency, stalls and
// redirects checked against a PC/retire model kept in the bench.
module tb_fetch_stage;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst, rst_w;
    logic        imem_req_ready, imem_rsp_valid, instr_ready, PCSrc;
    logic [31:0] imem_rsp_data, PCTarget;

    logic        a_req_valid, a_instr_valid, a_fault;
    logic [31:0] a_req_addr, a_instr, a_pc, a_pcp4, a_retire;
    logic [6:0]  a_op, a_f7;
    logic [2:0]  a_f3;
    logic        b_req_valid, b_instr_valid, b_fault;
    logic [31:0] b_req_addr, b_instr, b_pc, b_pcp4, b_retire;
    logic [6:0]  b_op, b_f7;
    logic [2:0]  b_f3;

    logic        o_req_valid, o_instr_valid, o_fault;
    logic [31:0] o_req_addr, o_instr, o_pc, o_pcp4, o_retire;
    logic [6:0]  o_op, o_f7;
    logic [2:0]  o_f3;
    logic        sel_w;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          t_valid = 0;

    logic [31:0] m_pc, m_retire, m_instr, m_reset_pc;
    logic        m_fault;

    fetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(a_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(a_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(a_instr_valid),
        .instr_ready(instr_ready), .Instr(a_instr), .Op(a_op),
        .funct3(a_f3), .funct7(a_f7), .PC(a_pc), .PCPlus4(a_pcp4),
        .PCSrc(PCSrc), .PCTarget(PCTarget), .fault(a_fault),
        .retire_count(a_retire)
    );

    fetch_stage #(.RESET_PC(WRAP_PC)) dut_w (
        .clk(clk), .rst(rst_w),
        .imem_req_valid(b_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(b_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(b_instr_valid),
        .instr_ready(instr_ready), .Instr(b_instr), .Op(b_op),
        .funct3(b_f3), .funct7(b_f7), .PC(b_pc), .PCPlus4(b_pcp4),
        .PCSrc(PCSrc), .PCTarget(PCTarget), .fault(b_fault),
        .retire_count(b_retire)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        o_req_valid   = sel_w ? b_req_valid   : a_req_valid;
        o_req_addr    = sel_w ? b_req_addr    : a_req_addr;
        o_instr_valid = sel_w ? b_instr_valid : a_instr_valid;
        o_instr       = sel_w ? b_instr       : a_instr;
        o_op          = sel_w ? b_op          : a_op;
        o_f3          = sel_w ? b_f3          : a_f3;
        o_f7          = sel_w ? b_f7          : a_f7;
        o_pc          = sel_w ? b_pc          : a_pc;
        o_pcp4        = sel_w ? b_pcp4        : a_pcp4;
        o_fault       = sel_w ? b_fault       : a_fault;
        o_retire      = sel_w ? b_retire      : a_retire;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_rst(input logic v);
        if (sel_w) rst_w = v;
        else       rst   = v;
    endtask

    // Reset the selected DUT, check reset values, then check the first request.
    task automatic do_reset();
        set_rst(1'b0);
        tick();
        tick();
        m_pc = m_reset_pc; m_retire = 0; m_fault = 0; m_instr = NOP;
        checks++;
        if (o_req_valid !== 1'b0 || o_instr_valid !== 1'b0 || o_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got req=%b ivalid=%b fault=%b expected 0 0 0",
                     o_req_valid, o_instr_valid, o_fault);
        end
        checks++;
        if (o_instr !== NOP || o_pc !== m_reset_pc || o_retire !== 32'd0 ||
            o_pcp4 !== m_reset_pc + 32'd4) begin
            failures++;
            $display("FAIL reset_regs: got instr=%h pc=%h retire=%h pcp4=%h expected %h %h 0 %h",
                     o_instr, o_pc, o_retire, o_pcp4, NOP, m_reset_pc, m_reset_pc + 32'd4);
        end
        set_rst(1'b1);
        tick();
        checks++;
        if (o_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_cycle: got req_valid=%b expected 0", o_req_valid);
        end
        tick();
        checks++;
        if (o_req_valid !== 1'b1 || o_req_addr !== m_reset_pc) begin
            failures++;
            $display("FAIL first_req: got valid=%b addr=%h expected 1 %h",
                     o_req_valid, o_req_addr, m_reset_pc);
        end
    endtask

    task automatic fetch_one(input logic [31:0] data, input int lat, input bit stray);
        int n;
        n = 0;
        while (!o_req_valid && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (o_req_valid !== 1'b1 || o_req_addr !== m_pc) begin
            failures++;
            $display("FAIL req_addr: got valid=%b addr=%h expected 1 %h",
                     o_req_valid, o_req_addr, m_pc);
        end
        if (stray) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
            tick();
            imem_rsp_valid = 1'b0;
            checks++;
            if (o_req_valid !== 1'b1 || o_instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL stray_req: got req=%b ivalid=%b expected 1 0",
                         o_req_valid, o_instr_valid);
            end
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        checks++;
        if (o_req_valid !== 1'b0 || o_instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL wait_quiet: got req=%b ivalid=%b expected 0 0",
                     o_req_valid, o_instr_valid);
        end
        for (int i = 0; i < lat; i++) tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        m_instr = data;
        t_valid = cyc;
        checks++;
        if (o_instr_valid !== 1'b1 || o_instr !== data || o_pc !== m_pc ||
            o_pcp4 !== m_pc + 32'd4) begin
            failures++;
            $display("FAIL hold_out: got ivalid=%b instr=%h pc=%h pcp4=%h expected 1 %h %h %h",
                     o_instr_valid, o_instr, o_pc, o_pcp4, data, m_pc, m_pc + 32'd4);
        end
        checks++;
        if (o_op !== data[6:0] || o_f3 !== data[14:12] || o_f7 !== data[31:25]) begin
            failures++;
            $display("FAIL decode: got op=%h f3=%h f7=%h expected %h %h %h",
                     o_op, o_f3, o_f7, data[6:0], data[14:12], data[31:25]);
        end
    endtask

    task automatic stall(input int cycles, input bit stray);
        for (int i = 0; i < cycles; i++) begin
            instr_ready = 1'b0;
            PCSrc       = 1'($urandom);
            PCTarget    = $urandom;
            if (stray) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = $urandom;
            end
            tick();
            imem_rsp_valid = 1'b0;
            checks++;
            if (o_instr_valid !== 1'b1 || o_req_valid !== 1'b0 ||
                o_instr !== m_instr || o_pc !== m_pc || o_retire !== m_retire) begin
                failures++;
                $display("FAIL stall: got ivalid=%b req=%b instr=%h pc=%h retire=%0d expected 1 0 %h %h %0d",
                         o_instr_valid, o_req_valid, o_instr, o_pc, o_retire,
                         m_instr, m_pc, m_retire);
            end
        end
        PCSrc = 1'b0;
    endtask

    task automatic consume(input bit src, input logic [31:0] tgt);
        PCSrc       = src;
        PCTarget    = tgt;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        PCTarget    = $urandom;
        m_retire    = m_retire + 32'd1;
        if (src && tgt[1:0] != 2'b00) m_fault = 1'b1;
        else                          m_pc = src ? tgt : m_pc + 32'd4;
        checks++;
        if (o_retire !== m_retire || o_fault !== m_fault || o_pc !== m_pc ||
            o_instr_valid !== 1'b0 || o_req_valid !== !m_fault) begin
            failures++;
            $display("FAIL consume: got retire=%0d fault=%b pc=%h ivalid=%b req=%b expected %0d %b %h 0 %b",
                     o_retire, o_fault, o_pc, o_instr_valid, o_req_valid,
                     m_retire, m_fault, m_pc, !m_fault);
        end
        if (!m_fault) begin
            checks++;
            if (o_req_addr !== m_pc) begin
                failures++;
                $display("FAIL next_addr: got %h expected %h", o_req_addr, m_pc);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_sequential();
        int t0;
        fetch_one($urandom, 0, 1'b0);
        consume(1'b0, $urandom);
        t0 = t_valid;
        fetch_one($urandom, 0, 1'b0);
        checks++;
        if (t_valid - t0 !== 3) begin
            failures++;
            $display("FAIL throughput: got %0d cycles expected 3", t_valid - t0);
        end
        consume(1'b0, $urandom);
        fetch_one($urandom, 0, 1'b0);
        consume(1'b0, $urandom);
        checks++;
        if (o_retire !== 32'd3 || o_req_addr !== 32'd12) begin
            failures++;
            $display("FAIL seq_three: got retire=%0d addr=%h expected 3 0000000c",
                     o_retire, o_req_addr);
        end
    endtask

    task automatic test_redirect();
        fetch_one($urandom, 1, 1'b0);
        consume(1'b1, 32'h0000_0100);
        fetch_one($urandom, 0, 1'b0);
        checks++;
        if (o_pcp4 !== 32'h0000_0104) begin
            failures++;
            $display("FAIL redirect_pcp4: got %h expected 00000104", o_pcp4);
        end
        consume(1'b0, 32'h0000_0003);
    endtask

    task automatic test_hold_stall();
        fetch_one($urandom, 2, 1'b1);
        stall(5, 1'b1);
        consume(1'b0, $urandom);
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        for (int k = 0; k < 25; k++) begin
            fetch_one($urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            stall(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            tgt = $urandom & 32'hFFFF_FFFC;
            consume($urandom_range(0, 2) == 0, tgt);
        end
    endtask

    task automatic test_fault();
        fetch_one($urandom, 0, 1'b0);
        consume(1'b1, 32'h0000_0102);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) imem_rsp_valid = 1'b1;
            tick();
            imem_rsp_valid = 1'b0;
            checks++;
            if (o_req_valid !== 1'b0 || o_instr_valid !== 1'b0 || o_fault !== 1'b1 ||
                o_pc !== m_pc || o_retire !== m_retire) begin
                failures++;
                $display("FAIL fault_hold: got req=%b ivalid=%b fault=%b pc=%h retire=%0d expected 0 0 1 %h %0d",
                         o_req_valid, o_instr_valid, o_fault, o_pc, o_retire, m_pc, m_retire);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fetch_one($urandom, 0, 1'b0);
        consume(1'b1, 32'h0000_0040);
        checks++;
        if (o_req_valid !== 1'b1 || o_req_addr !== 32'h0000_0040) begin
            failures++;
            $display("FAIL mid_req: got valid=%b addr=%h expected 1 00000040",
                     o_req_valid, o_req_addr);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        do_reset();
    endtask

    task automatic test_wrap();
        rst   = 1'b0;
        sel_w = 1'b1;
        m_reset_pc = WRAP_PC;
        do_reset();
        fetch_one($urandom, 0, 1'b1);
        stall(2, 1'b1);
        consume(1'b0, 32'h0000_0100);
        checks++;
        if (o_req_addr !== 32'h0000_0000) begin
            failures++;
            $display("FAIL wrap_addr: got %h expected 00000000", o_req_addr);
        end
        fetch_one($urandom, 1, 1'b1);
        consume(1'b0, $urandom);
    endtask

    initial begin
        rst = 1'b0; rst_w = 1'b0; sel_w = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; instr_ready = 1'b0;
        PCSrc = 1'b0; PCTarget = '0; imem_rsp_data = '0;
        m_reset_pc = 32'h0;
        tick();
        test_reset();
        test_sequential();
        test_redirect();
        test_hold_stall();
        test_random();
        test_fault();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
